// File: rtl/interface_wrapper_buf_pkg.sv
// Shared constants and helpers for the HWPE <-> flat stream wrapper with per-channel FIFOs.
package interface_wrapper_buf_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH      = 2;
   localparam int unsigned STAT_CNT_WIDTH     = 32;

   // Pointer width for a power-of-two depth; the occupancy count needs one extra bit.
   function automatic int unsigned clog2_depth(input int unsigned depth);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << r) < depth) r = r + 1;
      end
      return r;
   endfunction

   typedef logic [clog2_depth(DEFAULT_DEPTH):0] fifo_cnt_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE valid/ready stream interface with byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input ready);
   modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/interface_wrapper_buf_stream_fifo_sync.sv
// Single-channel synchronous FIFO with flush; registered read, ready depends on state only.
module stream_fifo_sync
   import interface_wrapper_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i
);

   localparam int unsigned AW = clog2_depth(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  push, pop;

   // Full refuses pushes even when a pop frees a slot in the same cycle.
   assign in_ready_o  = rst_ni & (cnt_q != CW'(DEPTH));
   assign out_valid_o = (cnt_q != '0);
   assign out_data_o  = mem_q[rptr_q];

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         if (push && !pop) cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !clear_i) mem_q[wptr_q] <= in_data_i;
   end

endmodule

// File: rtl/interface_wrapper_buf.sv
// Buffered bridge between HWPE streams and flat valid/ready ports, one FIFO per channel.
// Optional per-channel pop counters on beat_cnt_o when INTERFACE_WRAPPER_BUF_STATS_EN is defined.
module interface_wrapper_buf
   import interface_wrapper_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned N_IN       = 1,
   parameter int unsigned N_OUT      = 1,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   hwpe_stream_intf_stream.sink        a_i [N_IN-1:0],
   output logic [N_IN*DATA_WIDTH-1:0]  a_data_o,
   output logic [N_IN-1:0]             a_valid_o,
   input  logic [N_IN-1:0]             a_ready_i,
   input  logic [N_OUT*DATA_WIDTH-1:0] d_data_i,
   input  logic [N_OUT-1:0]            d_valid_i,
   output logic [N_OUT-1:0]            d_ready_o,
   hwpe_stream_intf_stream.source      d_o [N_OUT-1:0]
`ifdef INTERFACE_WRAPPER_BUF_STATS_EN
   ,
   output logic [(N_IN+N_OUT)*STAT_CNT_WIDTH-1:0] beat_cnt_o
`endif
);

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      stream_fifo_sync #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clear_i     (clear_i),
         .in_data_i   (a_i[k].data),
         .in_valid_i  (a_i[k].valid),
         .in_ready_o  (a_i[k].ready),
         .out_data_o  (a_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
         .out_valid_o (a_valid_o[k]),
         .out_ready_i (a_ready_i[k])
      );
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign d_o[k].strb = '1;
      stream_fifo_sync #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clear_i     (clear_i),
         .in_data_i   (d_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .in_valid_i  (d_valid_i[k]),
         .in_ready_o  (d_ready_o[k]),
         .out_data_o  (d_o[k].data),
         .out_valid_o (d_o[k].valid),
         .out_ready_i (d_o[k].ready)
      );
   end

`ifdef INTERFACE_WRAPPER_BUF_STATS_EN
   localparam int unsigned N_CH = N_IN + N_OUT;

   logic [N_CH-1:0] pop;

   for (genvar k = 0; k < N_IN; k++) begin : g_pop_in
      assign pop[k] = a_valid_o[k] & a_ready_i[k];
   end
   for (genvar k = 0; k < N_OUT; k++) begin : g_pop_out
      assign pop[N_IN+k] = d_o[k].valid & d_o[k].ready;
   end

   // Input channels occupy the low slices, output channels follow.
   for (genvar c = 0; c < N_CH; c++) begin : g_stat
      logic [STAT_CNT_WIDTH-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (clear_i) cnt_d = '0;
         else if (pop[c]) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) cnt_q <= '0;
         else         cnt_q <= cnt_d;
      end

      assign beat_cnt_o[c*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_interface_wrapper_buf.sv
// Randomised bench for interface_wrapper_buf against a queue-based channel model.
module tb_interface_wrapper_buf;
   import interface_wrapper_buf_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned N_IN  = 2;
   localparam int unsigned N_OUT = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NCH   = N_IN + N_OUT;

   logic clk;
   logic rst_n;
   logic clear;

   // Channel view: 0..N_IN-1 are HWPE-in -> flat, then flat -> HWPE-out.
   logic          in_vld  [NCH];
   logic [DW-1:0] in_dat  [NCH];
   logic          out_rdy [NCH];
   logic          in_rdy_w  [NCH];
   logic          out_vld_w [NCH];
   logic [DW-1:0] out_dat_w [NCH];

   logic [N_IN*DW-1:0]  a_data_flat;
   logic [N_IN-1:0]     a_valid_v;
   logic [N_IN-1:0]     a_ready_v;
   logic [N_OUT*DW-1:0] d_data_flat;
   logic [N_OUT-1:0]    d_valid_v;
   logic [N_OUT-1:0]    d_ready_v;
`ifdef INTERFACE_WRAPPER_BUF_STATS_EN
   logic [NCH*STAT_CNT_WIDTH-1:0] beat_cnt;
`endif

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) a_if [N_IN-1:0] ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) d_if [N_OUT-1:0] ();

   for (genvar g = 0; g < N_IN; g++) begin : g_a
      assign a_if[g].valid = in_vld[g];
      assign a_if[g].data  = in_dat[g];
      assign a_if[g].strb  = '1;
      assign in_rdy_w[g]   = a_if[g].ready;
      assign out_vld_w[g]  = a_valid_v[g];
      assign out_dat_w[g]  = a_data_flat[g*DW +: DW];
      assign a_ready_v[g]  = out_rdy[g];
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_d
      assign d_valid_v[g]           = in_vld[N_IN+g];
      assign d_data_flat[g*DW +: DW] = in_dat[N_IN+g];
      assign in_rdy_w[N_IN+g]       = d_ready_v[g];
      assign out_vld_w[N_IN+g]      = d_if[g].valid;
      assign out_dat_w[N_IN+g]      = d_if[g].data;
      assign d_if[g].ready          = out_rdy[N_IN+g];
   end

   interface_wrapper_buf #(
      .DATA_WIDTH (DW),
      .N_IN       (N_IN),
      .N_OUT      (N_OUT),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_i   (clear),
      .a_i       (a_if),
      .a_data_o  (a_data_flat),
      .a_valid_o (a_valid_v),
      .a_ready_i (a_ready_v),
      .d_data_i  (d_data_flat),
      .d_valid_i (d_valid_v),
      .d_ready_o (d_ready_v),
      .d_o       (d_if)
`ifdef INTERFACE_WRAPPER_BUF_STATS_EN
      ,
      .beat_cnt_o (beat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: each channel is an ordered queue of at most DEPTH beats.
   logic [DW-1:0] mq [NCH][$];

   always @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int c = 0; c < NCH; c++) mq[c].delete();
      end else begin
         for (int c = 0; c < NCH; c++) begin
            bit do_pop, do_push;
            do_pop  = (mq[c].size() > 0) && out_rdy[c];
            do_push = in_vld[c] && (mq[c].size() < DEPTH);
            if (do_pop)  void'(mq[c].pop_front());
            if (do_push) mq[c].push_back(in_dat[c]);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("valid_ch%0d", c), 32'(out_vld_w[c]), 32'(mq[c].size() > 0));
            if (mq[c].size() > 0) chk($sformatf("data_ch%0d", c), out_dat_w[c], mq[c][0]);
            chk($sformatf("ready_ch%0d", c), 32'(in_rdy_w[c]),
                32'(rst_n && (mq[c].size() < DEPTH)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int c = 0; c < NCH; c++) begin
         in_vld[c]  = 1'b0;
         in_dat[c]  = '0;
         out_rdy[c] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] got [$];
      logic [DW-1:0] nxt;
      logic          acc0;
      int            pushes, pops;

      rst_n = 1'b0;
      clear = 1'b0;
      idle_inputs();
      @(posedge clk);
      chk_en = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < NCH; c++) begin
            chk("rst_valid", 32'(out_vld_w[c]), 32'd0);
            chk("rst_ready", 32'(in_rdy_w[c]), 32'd0);
         end
         tick();
      end

      // Single beat: visible exactly one cycle after the push edge.
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(in_rdy_w[0]), 32'd1);
      in_vld[0] = 1'b1;
      in_dat[0] = 32'hDEADBEEF;
      chk("pre_push_valid", 32'(out_vld_w[0]), 32'd0);
      tick();
      in_vld[0] = 1'b0;
      chk("t1_valid", 32'(out_vld_w[0]), 32'd1);
      chk("t1_data", out_dat_w[0], 32'hDEADBEEF);
      out_rdy[0] = 1'b1;
      tick();
      out_rdy[0] = 1'b0;
      chk("t1_drained", 32'(out_vld_w[0]), 32'd0);

      // Fill to full with the consumer stalled, then drain while pushing 5 and 6.
      for (int v = 1; v <= 4; v++) begin
         in_vld[0] = 1'b1;
         in_dat[0] = 32'(v);
         tick();
      end
      in_dat[0] = 32'd5;
      chk("full_ready", 32'(in_rdy_w[0]), 32'd0);
      tick();
      chk("full_ready_hold", 32'(in_rdy_w[0]), 32'd0);
      out_rdy[0] = 1'b1;
      nxt = 32'd5;
      acc0 = in_rdy_w[0];
      for (int cyc = 0; cyc < 30 && got.size() < 6; cyc++) begin
         logic accepted;
         in_vld[0] = (nxt <= 32'd6);
         in_dat[0] = nxt;
         accepted = in_vld[0] && in_rdy_w[0];
         if (out_vld_w[0]) got.push_back(out_dat_w[0]);
         tick();
         if (accepted) nxt = nxt + 32'd1;
      end
      in_vld[0]  = 1'b0;
      out_rdy[0] = 1'b0;
      chk("full_pop_refused", 32'(acc0), 32'd0);
      chk("order_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < got.size() && i < 6; i++)
         chk($sformatf("order_%0d", i), got[i], 32'(i + 1));

      // Clear: buffered beats and the same-cycle push are discarded.
      in_vld[1] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_dat[1] = 32'(i * 32'h11);
         tick();
      end
      chk("clr_pre_valid", 32'(out_vld_w[1]), 32'd1);
      clear     = 1'b1;
      in_dat[1] = 32'hAA;
      tick();
      clear     = 1'b0;
      in_vld[1] = 1'b0;
      chk("clr_valid", 32'(out_vld_w[1]), 32'd0);
      chk("clr_ready", 32'(in_rdy_w[1]), 32'd1);
      in_vld[1] = 1'b1;
      in_dat[1] = 32'hBB;
      tick();
      in_vld[1] = 1'b0;
      chk("clr_next_valid", 32'(out_vld_w[1]), 32'd1);
      chk("clr_next_data", out_dat_w[1], 32'hBB);

      // Random streaming on every channel with occasional clear and one reset pulse.
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < NCH; c++) begin
            in_vld[c]  = ($urandom_range(0, 2) != 0);
            in_dat[c]  = $urandom;
            out_rdy[c] = ($urandom_range(0, 1) != 0);
         end
         clear = ($urandom_range(0, 79) == 0);
         rst_n = !(cyc == 300 || cyc == 301);
         tick();
      end
      clear = 1'b0;
      rst_n = 1'b1;

      // Always-ready consumer: one beat per cycle on an output channel.
      idle_inputs();
      for (int c = 0; c < NCH; c++) out_rdy[c] = 1'b1;
      repeat (6) tick();
      pushes = 0;
      pops   = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_vld[N_IN] = 1'b1;
         in_dat[N_IN] = $urandom;
         if (in_rdy_w[N_IN]) pushes++;
         if (out_vld_w[N_IN]) pops++;
         tick();
      end
      in_vld[N_IN] = 1'b0;
      chk("tput_pushes", 32'(pushes), 32'd20);
      chk("tput_pops", 32'(pops), 32'd19);

`ifdef INTERFACE_WRAPPER_BUF_STATS_EN
      idle_inputs();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("stat_cleared", beat_cnt[31:0], 32'd0);
      out_rdy[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_vld[0] = 1'b1;
         in_dat[0] = 32'(i);
         tick();
      end
      in_vld[0] = 1'b0;
      repeat (3) tick();
      chk("stat_seven", beat_cnt[31:0], 32'd7);
      force dut.g_stat[0].cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.g_stat[0].cnt_q;
      in_vld[0] = 1'b1;
      in_dat[0] = 32'h5A;
      tick();
      in_vld[0] = 1'b0;
      tick();
      chk("stat_wrap", beat_cnt[31:0], 32'd0);
`endif

      idle_inputs();
      repeat (3) tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
